// File: rtl/pe_mac_seq.sv
// pe_mac_seq: control sequencer for one row of bit-serial MAC PEs (clear, weight load, cfg_k MACs, drain, done).
// Latency: start sampled at edge t -> clr_* visible in cycle t+1; every output is a register.
// Backpressure: hold in RUN freezes the beat pointer and drops en_i/en_o/mac_done; the stalled beat is reissued once hold falls.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start               job request, only looked at in IDLE
//   cfg_k, cfg_drain    MACs per job and skew-drain cycles, latched on an accepted start
//   hold                operand not ready, stalls RUN only
//   busy, done          job in progress / one-cycle completion pulse
//   idx                 bit index driven to the PE row
//   en_i/clr_i, en_w/clr_w, en_o/clr_o   ifm, weight and accumulator register controls
//   mac_done            marks the final beat of the final MAC
// Optional build macro PE_MAC_SEQ_PERF_EN adds stall_cnt (RUN cycles with hold)
// and job_cnt (completed jobs); both saturate and clear only on rst.
module pe_mac_seq #(
  parameter int IWIDTH = 8,
  parameter int IDEPTH = 3,
  parameter int KWIDTH = 16,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KWIDTH-1:0] cfg_k,
  input  logic [DWIDTH-1:0] cfg_drain,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [IDEPTH-1:0] idx,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              mac_done
`ifdef PE_MAC_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       job_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_WLOAD = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [IDEPTH-1:0] IDX_LAST = IDEPTH'(IWIDTH - 1);

  state_t              state_q, state_d;
  logic [KWIDTH-1:0]   cfgk_q, cfgk_d;
  logic [DWIDTH-1:0]   cfgd_q, cfgd_d;
  // Beat pointer: the (bit, MAC) pair that the next issued RUN beat will carry.
  logic [IDEPTH-1:0]   pidx_q, pidx_d;
  logic [KWIDTH-1:0]   pk_q, pk_d;
  // Number of DRAIN cycles already presented, counting the current one.
  logic [DWIDTH-1:0]   dcnt_q, dcnt_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDEPTH-1:0]   idx_q, idx_d;
  logic                en_i_q, en_i_d;
  logic                clr_i_q, clr_i_d;
  logic                en_w_q, en_w_d;
  logic                clr_w_q, clr_w_d;
  logic                en_o_q, en_o_d;
  logic                clr_o_q, clr_o_d;
  logic                mac_done_q, mac_done_d;

  logic                issue;
  logic                enter_drain;
  logic                last_beat;

  assign last_beat = (pidx_q == IDX_LAST) && (pk_q == cfgk_q - KWIDTH'(1));

  always_comb begin
    state_d     = state_q;
    cfgk_d      = cfgk_q;
    cfgd_d      = cfgd_q;
    pidx_d      = pidx_q;
    pk_d        = pk_q;
    dcnt_d      = dcnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    idx_d       = '0;
    en_i_d      = 1'b0;
    clr_i_d     = 1'b0;
    en_w_d      = 1'b0;
    clr_w_d     = 1'b0;
    en_o_d      = 1'b0;
    clr_o_d     = 1'b0;
    mac_done_d  = 1'b0;
    issue       = 1'b0;
    enter_drain = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfgk_d  = cfg_k;
          cfgd_d  = cfg_drain;
          pidx_d  = '0;
          pk_d    = '0;
          dcnt_d  = '0;
          state_d = ST_CLR;
          busy_d  = 1'b1;
          clr_i_d = 1'b1;
          clr_w_d = 1'b1;
          clr_o_d = 1'b1;
        end
      end
      ST_CLR: begin
        state_d = ST_WLOAD;
        busy_d  = 1'b1;
        en_w_d  = 1'b1;
      end
      ST_WLOAD: begin
        // hold is not consulted here: the first beat of MAC 0 always issues.
        busy_d = 1'b1;
        if (cfgk_q != '0) begin
          issue = 1'b1;
        end else begin
          enter_drain = 1'b1;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (mac_done_q) begin
          // Final beat already presented; nothing left to stall.
          enter_drain = 1'b1;
        end else if (hold) begin
          // Bubble: show the pending beat's idx with all enables low.
          idx_d = pidx_q;
        end else begin
          issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        if (dcnt_q == cfgd_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DWIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue) begin
      state_d    = ST_RUN;
      idx_d      = pidx_q;
      en_i_d     = (pidx_q == '0);
      en_o_d     = 1'b1;
      mac_done_d = last_beat;
      // The pointer is left alone after the final beat so pk never exceeds cfg_k-1.
      if (!last_beat) begin
        if (pidx_q == IDX_LAST) begin
          pidx_d = '0;
          pk_d   = pk_q + KWIDTH'(1);
        end else begin
          pidx_d = pidx_q + IDEPTH'(1);
        end
      end
    end

    if (enter_drain) begin
      if (cfgd_q == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_DRAIN;
        dcnt_d  = DWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cfgk_q     <= '0;
      cfgd_q     <= '0;
      pidx_q     <= '0;
      pk_q       <= '0;
      dcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      en_i_q     <= 1'b0;
      clr_i_q    <= 1'b0;
      en_w_q     <= 1'b0;
      clr_w_q    <= 1'b0;
      en_o_q     <= 1'b0;
      clr_o_q    <= 1'b0;
      mac_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfgk_q     <= cfgk_d;
      cfgd_q     <= cfgd_d;
      pidx_q     <= pidx_d;
      pk_q       <= pk_d;
      dcnt_q     <= dcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      en_i_q     <= en_i_d;
      clr_i_q    <= clr_i_d;
      en_w_q     <= en_w_d;
      clr_w_q    <= clr_w_d;
      en_o_q     <= en_o_d;
      clr_o_q    <= clr_o_d;
      mac_done_q <= mac_done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign idx      = idx_q;
  assign en_i     = en_i_q;
  assign clr_i    = clr_i_q;
  assign en_w     = en_w_q;
  assign clr_w    = clr_w_q;
  assign en_o     = en_o_q;
  assign clr_o    = clr_o_q;
  assign mac_done = mac_done_q;

`ifdef PE_MAC_SEQ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] job_cnt_q, job_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    job_cnt_d   = job_cnt_q;
    if ((state_q == ST_RUN) && hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // Counted on the edge that raises done so the count and the pulse appear together.
    if (done_d && (job_cnt_q != '1)) begin
      job_cnt_d = job_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      job_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      job_cnt_q   <= job_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign job_cnt   = job_cnt_q;
`endif

endmodule

// File: tb/tb_pe_mac_seq.sv
// tb_pe_mac_seq: drives an IWIDTH=8 and an IWIDTH=6 sequencer with one shared input schedule.
// Latency: expected traces are built per job from the sequencing rules, one entry per cycle.
// Backpressure: hold patterns are part of the schedule; stalls are inserted into the expected trace.
module tb_pe_mac_seq;

  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [15:0] cfg_k;
  logic [7:0]  cfg_drain;

  logic [1:0]  busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done;
  logic [2:0]  idx_w [2];
`ifdef PE_MAC_SEQ_PERF_EN
  logic [31:0] stall_cnt [2];
  logic [15:0] job_cnt [2];
`endif

  always #5 clk = ~clk;

  pe_mac_seq #(.IWIDTH(8), .IDEPTH(3), .KWIDTH(16), .DWIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_drain(cfg_drain), .hold(hold),
    .busy(busy[0]), .done(done[0]), .idx(idx_w[0]), .en_i(en_i[0]), .clr_i(clr_i[0]),
    .en_w(en_w[0]), .clr_w(clr_w[0]), .en_o(en_o[0]), .clr_o(clr_o[0]), .mac_done(mac_done[0])
`ifdef PE_MAC_SEQ_PERF_EN
    , .stall_cnt(stall_cnt[0]), .job_cnt(job_cnt[0])
`endif
  );

  pe_mac_seq #(.IWIDTH(6), .IDEPTH(3), .KWIDTH(16), .DWIDTH(8)) u_dut6 (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_drain(cfg_drain), .hold(hold),
    .busy(busy[1]), .done(done[1]), .idx(idx_w[1]), .en_i(en_i[1]), .clr_i(clr_i[1]),
    .en_w(en_w[1]), .clr_w(clr_w[1]), .en_o(en_o[1]), .clr_o(clr_o[1]), .mac_done(mac_done[1])
`ifdef PE_MAC_SEQ_PERF_EN
    , .stall_cnt(stall_cnt[1]), .job_cnt(job_cnt[1])
`endif
  );

  // Input schedule indexed by edge; traces indexed by the cycle following edge e (= e+1).
  bit          rst_s   [MAXC];
  bit          start_s [MAXC];
  bit          hold_s  [MAXC];
  logic [15:0] k_s     [MAXC];
  logic [7:0]  d_s     [MAXC];
  // Trace word: {busy, done, idx[2:0], en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done}
  logic [11:0] act  [2][MAXC];
  logic [11:0] expv [2][MAXC];

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [11:0] mk(input logic bz, input logic dn, input logic [2:0] ix,
                                     input logic ei, input logic cl, input logic ew,
                                     input logic eo, input logic md);
    return {bz, dn, ix, ei, cl, ew, cl, eo, cl, md};
  endfunction

  function automatic int iw_of(input int w);
    return (w == 0) ? 8 : 6;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      rst_s[i] = 1'b0; start_s[i] = 1'b0; hold_s[i] = 1'b0;
      k_s[i] = '0; d_s[i] = '0;
      for (int w = 0; w < 2; w++) begin
        expv[w][i] = '0;
        act[w][i]  = '0;
      end
    end
  endtask

  // Expected cycles of one job accepted at edge e: CLR, WLOAD, beats (with hold bubbles), drain, DONE.
  task automatic model_job(input int w, input int e, input int k, input int d, output int done_p);
    int p;
    int iw;
    iw = iw_of(w);
    p = e + 1;
    expv[w][p] = mk(1, 0, 3'd0, 0, 1, 0, 0, 0); p++;
    expv[w][p] = mk(1, 0, 3'd0, 0, 0, 1, 0, 0); p++;
    for (int m = 0; m < k; m++) begin
      for (int b = 0; b < iw; b++) begin
        if (m != 0 || b != 0) begin
          while (hold_s[p-1] && p < MAXC - 2) begin
            expv[w][p] = mk(1, 0, 3'(b), 0, 0, 0, 0, 0); p++;
          end
        end
        expv[w][p] = mk(1, 0, 3'(b), (b == 0), 0, 0, 1, (m == k - 1) && (b == iw - 1)); p++;
      end
    end
    for (int i = 0; i < d; i++) begin
      expv[w][p] = mk(1, 0, 3'd0, 0, 0, 0, 0, 0); p++;
    end
    expv[w][p] = mk(1, 1, 3'd0, 0, 0, 0, 0, 0);
    done_p = p;
  endtask

  // Walks the schedule: a start is taken only once the previous job's DONE cycle is over;
  // reset wipes everything after it.
  task automatic model_sched(input int n);
    int free_e;
    int dp;
    for (int w = 0; w < 2; w++) begin
      free_e = 0;
      for (int e = 0; e < n; e++) begin
        if (rst_s[e]) begin
          for (int p = e + 1; p < MAXC; p++) expv[w][p] = '0;
          free_e = e + 1;
        end else if (start_s[e] && e >= free_e) begin
          model_job(w, e, int'(k_s[e]), int'(d_s[e]), dp);
          free_e = dp + 1;
        end
      end
    end
  endtask

  task automatic run_sched(input int n);
    for (int e = 0; e < n; e++) begin
      rst = rst_s[e]; start = start_s[e]; hold = hold_s[e];
      cfg_k = k_s[e]; cfg_drain = d_s[e];
      @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++)
        act[w][e+1] = {busy[w], done[w], idx_w[w], en_i[w], clr_i[w], en_w[w],
                       clr_w[w], en_o[w], clr_o[w], mac_done[w]};
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    n = 12;
    clear_sched();
    for (int e = 0; e < 3; e++) begin rst_s[e] = 1; start_s[e] = 1; k_s[e] = 16'd1; end
    start_s[3] = 1; k_s[3] = 16'd1; d_s[3] = 8'd0;
    model_sched(n);
    run_sched(n);
    for (int w = 0; w < 2; w++) begin
      n_chk++;
      if (act[w][3] !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_zero iw=%0d got=%h exp=000", iw_of(w), act[w][3]);
      end
    end
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL reset_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_basic();
    int n, b, nb, ne, nm;
    n = 40; b = 1;
    clear_sched();
    rst_s[0] = 1;
    start_s[b] = 1; k_s[b] = 16'd3; d_s[b] = 8'd4;
    model_sched(n);
    run_sched(n);
    nb = 0; ne = 0; nm = 0;
    for (int p = 1; p <= n; p++) begin
      nb += int'(act[0][p][11]); ne += int'(act[0][p][6]); nm += int'(act[0][p][0]);
    end
    n_chk++;
    if (nb != 31 || ne != 3 || nm != 1) begin
      n_fail++;
      $display("FAIL basic_counts busy=%0d en_i=%0d mac_done=%0d exp 31/3/1", nb, ne, nm);
    end
    n_chk++;
    if (act[0][b+1][5] !== 1'b1 || act[0][b+2][4] !== 1'b1 || act[0][b+3][6] !== 1'b1 ||
        act[0][b+11][6] !== 1'b1 || act[0][b+19][6] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_points clr=%b en_w=%b en_i=%b%b%b exp 1 1 111", act[0][b+1][5],
               act[0][b+2][4], act[0][b+3][6], act[0][b+11][6], act[0][b+19][6]);
    end
    n_chk++;
    if (act[0][b+26][0] !== 1'b1 || act[0][b+31][10] !== 1'b1 || act[0][b+32][11] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end mac_done@26=%b done@31=%b busy@32=%b exp 1 1 0",
               act[0][b+26][0], act[0][b+31][10], act[0][b+32][11]);
    end
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL basic_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_stall();
    int n, b;
    n = 45; b = 1;
    clear_sched();
    rst_s[0] = 1;
    start_s[b] = 1; k_s[b] = 16'd3; d_s[b] = 8'd4;
    for (int e = b + 15; e <= b + 17; e++) hold_s[e] = 1;
    model_sched(n);
    run_sched(n);
    for (int p = b + 16; p <= b + 18; p++) begin
      n_chk++;
      if (act[0][p][9:7] !== 3'd5 || act[0][p][2] !== 1'b0 || act[0][p][6] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_bubble cyc=%0d idx=%0d en_o=%b exp idx=5 en_o=0", p, act[0][p][9:7], act[0][p][2]);
      end
    end
    n_chk++;
    if (act[0][b+19][9:7] !== 3'd5 || act[0][b+19][2] !== 1'b1 || act[0][b+29][0] !== 1'b1 ||
        act[0][b+34][10] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_shift idx@19=%0d en_o@19=%b mac_done@29=%b done@34=%b exp 5 1 1 1",
               act[0][b+19][9:7], act[0][b+19][2], act[0][b+29][0], act[0][b+34][10]);
    end
`ifdef PE_MAC_SEQ_PERF_EN
    for (int w = 0; w < 2; w++) begin
      n_chk++;
      if (stall_cnt[w] !== 32'd3 || job_cnt[w] !== 16'd1) begin
        n_fail++;
        $display("FAIL stall_perf iw=%0d stall_cnt=%0d job_cnt=%0d exp 3 1", iw_of(w), stall_cnt[w], job_cnt[w]);
      end
    end
`endif
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL stall_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_zero();
    int n, b, nm;
    n = 10; b = 1;
    clear_sched();
    rst_s[0] = 1;
    start_s[b] = 1; k_s[b] = 16'd0; d_s[b] = 8'd0;
    model_sched(n);
    run_sched(n);
    for (int w = 0; w < 2; w++) begin
      nm = 0;
      for (int p = 1; p <= n; p++) nm += int'(act[w][p][6]) + int'(act[w][p][0]);
      n_chk++;
      if (act[w][b+3][10] !== 1'b1 || act[w][b+4][11] !== 1'b0 || nm != 0) begin
        n_fail++;
        $display("FAIL zero_job iw=%0d done@3=%b busy@4=%b en_i+mac_done=%0d exp 1 0 0",
                 iw_of(w), act[w][b+3][10], act[w][b+4][11], nm);
      end
    end
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL zero_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_busy_start();
    int n, b;
    n = 60; b = 1;
    clear_sched();
    rst_s[0] = 1;
    start_s[b] = 1;      k_s[b] = 16'd3;      d_s[b] = 8'd4;
    start_s[b+10] = 1;   k_s[b+10] = 16'd1;   d_s[b+10] = 8'd0;
    start_s[b+31] = 1;   k_s[b+31] = 16'd1;   d_s[b+31] = 8'd0;
    start_s[b+32] = 1;   k_s[b+32] = 16'd1;   d_s[b+32] = 8'd2;
    model_sched(n);
    run_sched(n);
    n_chk++;
    if (act[0][b+32][11] !== 1'b0 || act[0][b+33][5] !== 1'b1 || act[0][b+45][10] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start busy@32=%b clr@33=%b done@45=%b exp 0 1 1",
               act[0][b+32][11], act[0][b+33][5], act[0][b+45][10]);
    end
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL busy_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_reset_mid();
    int n, b, nd;
    n = 50; b = 1;
    clear_sched();
    rst_s[0] = 1;
    start_s[b] = 1;    k_s[b] = 16'd3;    d_s[b] = 8'd4;
    rst_s[b+15] = 1;
    start_s[b+20] = 1; k_s[b+20] = 16'd2; d_s[b+20] = 8'd1;
    model_sched(n);
    run_sched(n);
    nd = 0;
    for (int p = 1; p <= b + 20; p++) nd += int'(act[0][p][10]);
    n_chk++;
    if (act[0][b+16] !== 12'h000 || nd != 0 || act[0][b+21][5] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid out@16=%h done_pulses=%0d clr@21=%b exp 000 0 1",
               act[0][b+16], nd, act[0][b+21][5]);
    end
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL rstmid_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_idx_wrap();
    int n, b;
    n = 20; b = 1;
    clear_sched();
    rst_s[0] = 1;
    start_s[b] = 1; k_s[b] = 16'd2; d_s[b] = 8'd0;
    model_sched(n);
    run_sched(n);
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (act[1][b+3+i][9:7] !== 3'(i % 6) || act[1][b+3+i][0] !== (i == 11)) begin
        n_fail++;
        $display("FAIL wrap6 beat=%0d idx=%0d mac_done=%b exp idx=%0d mac_done=%b",
                 i, act[1][b+3+i][9:7], act[1][b+3+i][0], i % 6, i == 11);
      end
    end
    n_chk++;
    if (act[1][b+15][10] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap6_done got=%b exp=1", act[1][b+15][10]);
    end
    for (int p = 1; p <= n; p++)
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (act[w][p] !== expv[w][p]) begin
          n_fail++;
          $display("FAIL wrap_trace iw=%0d cyc=%0d got=%h exp=%h", iw_of(w), p, act[w][p], expv[w][p]);
        end
      end
  endtask

  task automatic test_random();
    int n;
    n = 200;
    for (int r = 0; r < 4; r++) begin
      clear_sched();
      rst_s[0] = 1;
      for (int e = 1; e < n; e++) begin
        start_s[e] = ($urandom_range(0, 5) == 0);
        k_s[e]     = 16'($urandom_range(0, 3));
        d_s[e]     = 8'($urandom_range(0, 4));
        hold_s[e]  = ($urandom_range(0, 3) == 0);
        rst_s[e]   = ($urandom_range(0, 150) == 0);
      end
      model_sched(n);
      run_sched(n);
      for (int p = 1; p <= n; p++)
        for (int w = 0; w < 2; w++) begin
          n_chk++;
          if (act[w][p] !== expv[w][p]) begin
            n_fail++;
            $display("FAIL random_trace round=%0d iw=%0d cyc=%0d got=%h exp=%h",
                     r, iw_of(w), p, act[w][p], expv[w][p]);
          end
        end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; cfg_k = '0; cfg_drain = '0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_busy_start();
    test_reset_mid();
    test_idx_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
